io_debounce_irq: RTL and testbench

//  Input-conditioning stage between the board pins (8 switches, 5 buttons) and the AXI-lite

---
 rtl/io_debounce_irq.sv | 166 ++++++++++++++++
 tb/tb_io_debounce_irq.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/io_debounce_irq.sv
// Input conditioning for board switches and buttons: 2-FF sync, tick-based
// debounce, edge detect, sticky interrupt status and a registered irq.

module io_deb_lane (
  input  logic       ACLK,
  input  logic       ARESETn,
  input  logic       pin,
  input  logic       run,
  input  logic       tick,
  input  logic       deb_ena,
  input  logic [4:0] deb_time,
  input  logic       int_ena,
  input  logic       pos_ena,
  input  logic       neg_ena,
  input  logic       clr,
  output logic       filt,
  output logic       sts
);
  logic       sync1, sync, filt_d;
  logic [4:0] cnt;
  logic       rise, fall, set;

  // two-flop synchroniser for the asynchronous pin
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      sync1 <= 1'b0;
      sync  <= 1'b0;
    end else begin
      sync1 <= pin;
      sync  <= sync1;
    end
  end

  // debounce filter; during INIT both filt and filt_d load the pin so the
  // first RUN cycle sees no edge
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      filt   <= 1'b0;
      filt_d <= 1'b0;
      cnt    <= '0;
    end else if (!run) begin
      filt   <= sync;
      filt_d <= sync;
      cnt    <= '0;
    end else begin
      filt_d <= filt;
      if (!deb_ena) begin
        filt <= sync;
        cnt  <= '0;
      end else if (sync == filt) begin
        cnt <= '0;
      end else if (tick) begin
        if (cnt >= deb_time) begin
          filt <= sync;
          cnt  <= '0;
        end else begin
          cnt <= cnt + 5'd1;
        end
      end
    end
  end

  assign rise = run &  filt & ~filt_d;
  assign fall = run & ~filt &  filt_d;
  assign set  = ((rise & pos_ena) | (fall & neg_ena)) & int_ena;

  // sticky status; a set in the same cycle as a clear wins
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) sts <= 1'b0;
    else          sts <= (sts & ~clr) | set;
  end
endmodule

module io_debounce_irq #(
  parameter int PRESCALE = 100000
) (
  input  logic       ACLK,
  input  logic       ARESETn,
  input  logic [7:0] switch_in,
  input  logic [4:0] button_in,
  output logic [7:0] switch_out,
  output logic [4:0] button_out,
  input  logic [7:0] deb_switch_ena,
  input  logic [4:0] deb_button_ena,
  input  logic [4:0] deb_time,
  input  logic [7:0] int_switch_ena,
  input  logic [4:0] int_button_ena,
  input  logic [4:0] button_posedge,
  input  logic [4:0] button_negedge,
  input  logic [7:0] int_switch_clr,
  input  logic [4:0] int_button_clr,
  output logic [7:0] int_switch_sts,
  output logic [4:0] int_button_sts,
  output logic       irq
);
  localparam int NUM_LANES = 13;
  localparam int PW        = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

  typedef enum logic {ST_INIT, ST_RUN} state_t;
  state_t          state;
  logic [1:0]      init_cnt;
  logic [PW-1:0]   pcnt;
  logic            run, tick;

  logic [NUM_LANES-1:0] pins, deb_ena, int_ena, pos_ena, neg_ena, clr;
  logic [NUM_LANES-1:0] filt, sts;

  // switches react to both edges; buttons use their per-edge selects
  assign pins    = {button_in, switch_in};
  assign deb_ena = {deb_button_ena, deb_switch_ena};
  assign int_ena = {int_button_ena, int_switch_ena};
  assign pos_ena = {button_posedge, 8'hFF};
  assign neg_ena = {button_negedge, 8'hFF};
  assign clr     = {int_button_clr, int_switch_clr};

  assign run  = (state == ST_RUN);
  assign tick = run && (pcnt == PW'(PRESCALE - 1));

  // INIT holds for 3 cycles after reset release to settle the synchronisers
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end else if (state == ST_INIT) begin
      if (init_cnt == 2'd2) state <= ST_RUN;
      else                  init_cnt <= init_cnt + 2'd1;
    end
  end

  // free-running debounce prescaler, parked at 0 outside RUN
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn)   pcnt <= '0;
    else if (!run)  pcnt <= '0;
    else if (tick)  pcnt <= '0;
    else            pcnt <= pcnt + PW'(1);
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    io_deb_lane u_lane (
      .ACLK     (ACLK),
      .ARESETn  (ARESETn),
      .pin      (pins[i]),
      .run      (run),
      .tick     (tick),
      .deb_ena  (deb_ena[i]),
      .deb_time (deb_time),
      .int_ena  (int_ena[i]),
      .pos_ena  (pos_ena[i]),
      .neg_ena  (neg_ena[i]),
      .clr      (clr[i]),
      .filt     (filt[i]),
      .sts      (sts[i])
    );
  end

  assign switch_out     = filt[7:0];
  assign button_out     = filt[12:8];
  assign int_switch_sts = sts[7:0];
  assign int_button_sts = sts[12:8];

  // level irq from enabled status, registered
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) irq <= 1'b0;
    else          irq <= |(sts & int_ena);
  end
endmodule

// File: tb/tb_io_debounce_irq.sv
// Directed bench for io_debounce_irq with PRESCALE=4 (tick every 4 cycles).
`timescale 1ns/1ps
module tb_io_debounce_irq;
  logic       ACLK = 1'b0;
  logic       ARESETn;
  logic [7:0] switch_in, switch_out, deb_switch_ena, int_switch_ena, int_switch_clr, int_switch_sts;
  logic [4:0] button_in, button_out, deb_button_ena, deb_time, int_button_ena;
  logic [4:0] button_posedge, button_negedge, int_button_clr, int_button_sts;
  logic       irq;

  int errors = 0;
  int checks = 0;
  int n;
  logic seen;

  io_debounce_irq #(.PRESCALE(4)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .switch_in(switch_in), .button_in(button_in),
    .switch_out(switch_out), .button_out(button_out),
    .deb_switch_ena(deb_switch_ena), .deb_button_ena(deb_button_ena), .deb_time(deb_time),
    .int_switch_ena(int_switch_ena), .int_button_ena(int_button_ena),
    .button_posedge(button_posedge), .button_negedge(button_negedge),
    .int_switch_clr(int_switch_clr), .int_button_clr(int_button_clr),
    .int_switch_sts(int_switch_sts), .int_button_sts(int_button_sts),
    .irq(irq)
  );

  always #5 ACLK = ~ACLK;

  // advance n clock edges, then settle 1 ns past the edge
  task automatic step(input int cyc);
    repeat (cyc) @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  initial begin
    ARESETn = 1'b0;
    switch_in = 8'hA5; button_in = 5'h00;
    deb_switch_ena = 8'hFF; deb_button_ena = 5'h1F; deb_time = 5'd2;
    int_switch_ena = 8'hFF; int_button_ena = 5'h00;
    button_posedge = 5'h1F; button_negedge = 5'h00;
    int_switch_clr = 8'h00; int_button_clr = 5'h00;

    // reset state
    step(3);
    chk("rst_switch_out", switch_out, 8'h00);
    chk("rst_button_out", button_out, 5'h00);
    chk("rst_sts", {int_button_sts, int_switch_sts}, 13'h0);
    chk("rst_irq", irq, 1'b0);

    // 1: release with A5 held; INIT loads it without raising status
    ARESETn = 1'b1;
    step(6);
    chk("init_switch_out", switch_out, 8'hA5);
    chk("init_sts", int_switch_sts, 8'h00);
    chk("init_irq", irq, 1'b0);

    // 2: debounced rise on switch1 (deb_time=2 -> 3 ticks)
    switch_in = 8'hA7;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      step(1); n++;
      if (switch_out[1]) break;
    end
    chk_range("deb_rise_latency", n, 10, 14);
    chk("deb_rise_val", switch_out, 8'hA7);
    step(1);
    chk("deb_sts_set", int_switch_sts, 8'h02);
    chk("deb_irq_lag", irq, 1'b0);
    step(1);
    chk("deb_irq", irq, 1'b1);
    int_switch_clr = 8'h02;
    step(1);
    int_switch_clr = 8'h00;
    chk("clr1_sts", int_switch_sts, 8'h00);
    step(1);
    chk("clr1_irq", irq, 1'b0);

    // 3: bounce on button2, 1-cycle pulses once per tick period, then hold
    seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      button_in = 5'h04;
      step(1); seen |= button_out[2];
      button_in = 5'h00;
      for (int j = 0; j < 3; j++) begin step(1); seen |= button_out[2]; end
    end
    step(4); seen |= button_out[2];
    chk("bounce_no_change", seen, 1'b0);
    button_in = 5'h04;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      step(1); n++;
      if (button_out[2]) break;
    end
    chk_range("bounce_hold_latency", n, 10, 14);
    chk("bounce_btn_sts", int_button_sts, 5'h00);

    // 4: negedge-only status on button0 (bypass filter for exact timing)
    deb_button_ena = 5'h1E; button_posedge = 5'h00; button_negedge = 5'h01;
    int_button_ena = 5'h01;
    step(1);
    button_in = 5'h05;
    step(2);
    chk("bypass_lat2", button_out, 5'h04);
    step(1);
    chk("bypass_lat3", button_out, 5'h05);
    step(3);
    chk("press_no_sts", int_button_sts, 5'h00);
    button_in = 5'h04;
    step(3);
    chk("release_out", button_out, 5'h04);
    step(1);
    chk("release_sts", int_button_sts, 5'h01);
    step(1);
    chk("release_irq", irq, 1'b1);
    int_button_ena = 5'h00;
    step(1);
    chk("mask_irq", irq, 1'b0);
    chk("mask_keeps_sts", int_button_sts, 5'h01);
    int_button_ena = 5'h01;
    step(1);
    chk("unmask_irq", irq, 1'b1);
    int_button_clr = 5'h01;
    step(1);
    int_button_clr = 5'h00;
    chk("btn_clr_sts", int_button_sts, 5'h00);
    step(1);
    chk("btn_clr_irq", irq, 1'b0);

    // 5: clear colliding with a new switch3 edge -> set wins
    deb_switch_ena = 8'hF7;
    switch_in = 8'hAF;
    step(4);
    chk("sw3_set", int_switch_sts, 8'h08);
    switch_in = 8'hA7;
    step(3);
    chk("sw3_fall_out", switch_out, 8'hA7);
    int_switch_clr = 8'h08;
    step(1);
    int_switch_clr = 8'h00;
    chk("set_wins", int_switch_sts, 8'h08);
    step(2);
    chk("sw3_irq", irq, 1'b1);
    int_switch_clr = 8'h08;
    step(1);
    int_switch_clr = 8'h00;
    chk("lone_clr_sts", int_switch_sts, 8'h00);
    step(1);
    chk("lone_clr_irq", irq, 1'b0);

    // 6: full bypass tracks with 3-cycle latency; then async reset mid-count
    deb_switch_ena = 8'h00;
    switch_in = 8'h3C;
    step(2);
    chk("track_lat2", switch_out, 8'hA7);
    step(1);
    chk("track_lat3", switch_out, 8'h3C);
    deb_switch_ena = 8'hFF; deb_time = 5'd10;
    switch_in = 8'hC3;
    step(10);
    chk("midcount_hold", switch_out, 8'h3C);
    ARESETn = 1'b0;
    #1;
    chk("async_switch_out", switch_out, 8'h00);
    chk("async_button_out", button_out, 5'h00);
    chk("async_sts", {int_button_sts, int_switch_sts}, 13'h0);
    chk("async_irq", irq, 1'b0);
    step(2);
    ARESETn = 1'b1;
    step(6);
    chk("rerun_switch_out", switch_out, 8'hC3);
    chk("rerun_button_out", button_out, 5'h04);
    chk("rerun_sts", {int_button_sts, int_switch_sts}, 13'h0);
    chk("rerun_irq", irq, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
